// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM-port arbiter: lock-state encoding, requester indices, stats width.
// The stats counters are only present when ARB_STATS_EN is defined.
package mem_port_arbiter_pkg;

    localparam int unsigned REQ_A  = 0;
    localparam int unsigned REQ_B  = 1;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_A    = 2'd1,
        LK_B    = 2'd2
    } lock_e;

    // prio is 0 for A and 1 for B, so it maps straight onto a one-hot grant.
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val, input logic en);
        if (en && (val != {STAT_W{1'b1}})) begin
            return val + 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin grant with lock masking; purely combinational.
// A held lock admits only its owner, even when the owner is idle.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  lock_e      lock_state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (lock_state)
            LK_A: gnt[REQ_A] = req[REQ_A];
            LK_B: gnt[REQ_B] = req[REQ_B];
            default: begin
                if (&req) begin
                    gnt = onehot_of(prio);
                end else begin
                    gnt = req;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between requester A (core) and B (debug loader).
// Optional per-requester grant and stall counters are built in when ARB_STATS_EN is defined.
//
// lock state | meaning
// LK_NONE    | round-robin between A and B
// LK_A       | only A may be granted
// LK_B       | only B may be granted
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt_a,
    output logic [STAT_W-1:0] stat_gnt_b,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    logic       prio_q, prio_d;
    lock_e      lock_q, lock_d;
    logic [1:0] rtag_q, rtag_d;
    logic [1:0] req;
    logic [1:0] gnt;

    assign req = {b_req, a_req};

    arb_rr2 u_arb (
        .req        (req),
        .prio       (prio_q),
        .lock_state (lock_q),
        .gnt        (gnt)
    );

    assign a_gnt = gnt[REQ_A];
    assign b_gnt = gnt[REQ_B];

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[REQ_A]) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (gnt[REQ_B]) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Only a granted access moves prio or the lock; an ungranted cycle holds both.
    always_comb begin
        prio_d = prio_q;
        lock_d = lock_q;
        if (gnt[REQ_A]) begin
            prio_d = 1'b1;
            lock_d = a_lock ? LK_A : LK_NONE;
        end else if (gnt[REQ_B]) begin
            prio_d = 1'b0;
            lock_d = b_lock ? LK_B : LK_NONE;
        end
        rtag_d = {gnt[REQ_B] & ~b_we, gnt[REQ_A] & ~a_we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
            lock_q <= LK_NONE;
            rtag_q <= 2'b00;
        end else begin
            prio_q <= prio_d;
            lock_q <= lock_d;
            rtag_q <= rtag_d;
        end
    end

    // RAM data arrives one cycle after the address, which is exactly when rtag is set.
    assign a_rvalid = rtag_q[REQ_A];
    assign b_rvalid = rtag_q[REQ_B];
    assign a_rdata  = rtag_q[REQ_A] ? mem_rdata : '0;
    assign b_rdata  = rtag_q[REQ_B] ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_gnt_a_q, stat_gnt_a_d;
    logic [STAT_W-1:0] stat_gnt_b_q, stat_gnt_b_d;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
    logic              stall;

    always_comb begin
        stall        = (a_req & ~gnt[REQ_A]) | (b_req & ~gnt[REQ_B]);
        stat_gnt_a_d = sat_inc(stat_gnt_a_q, gnt[REQ_A]);
        stat_gnt_b_d = sat_inc(stat_gnt_b_q, gnt[REQ_B]);
        stat_stall_d = sat_inc(stat_stall_q, stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt_a_q <= '0;
            stat_gnt_b_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_gnt_a_q <= stat_gnt_a_d;
            stat_gnt_b_q <= stat_gnt_b_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_gnt_a = stat_gnt_a_q;
    assign stat_gnt_b = stat_gnt_b_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the synchronous dual-port RAM (1-cycle read latency) between two masters: requester A (a core memory port) and requester B (the debug/program loader).
- Sits between the masters and the RAM port, alongside the system address decode; it sees only the RAM-local address.
- Round-robin arbitration, a bus-lock for read-modify-write sequences, and per-requester read-return tracking.

Parameters:
- ADDR_W, 14, RAM-local address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- a_req  in  1  A requests an access this cycle
- a_we  in  1  A write (1) / read (0)
- a_lock  in  1  A holds the port after this access
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A access accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Registers:
  - prio (next favoured requester): reset value A.
  - lock state: NONE / LOCK_A / LOCK_B, reset value NONE.
  - rtag[1:0] (pending read return for A/B): reset value 00.
- Grant, NONE state:
  - Only one requester: it is granted.
  - Both requesting: the prio requester is granted.
  - No request: no grant.
- Grant, LOCK_x state: only x may be granted. The other requester is stalled (gnt=0) even if x is idle.
- At most one gnt per cycle. gnt is combinational from req and state, with no extra latency.
- On a granted access, the registers update at the next edge:
  - prio goes to the other requester.
  - Lock state becomes LOCK_x if lock_x=1, else NONE.
  - A granted access with lock=0 is the only way to release a lock.
- Memory outputs:
  - Granted cycle: mem_we = we & gnt; mem_addr and mem_wdata are muxed from the granted requester.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read (we=0) sets rtag for that requester at the next edge.
  - In that next cycle, x_rvalid=1 and x_rdata=mem_rdata.
  - Otherwise x_rvalid=0 and x_rdata=0.
  - rtag is rewritten every cycle, so back-to-back reads give back-to-back rvalid.
- Writes produce no rvalid. Write-then-read of the same address on consecutive cycles returns the new data (RAM write-first on the same port).
- Output reset values:
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - mem_* follow the request inputs.
- Reset mid-operation: rst clears rtag, so a read granted in the reset cycle produces no rvalid. rst also clears the lock and sets prio back to A.
- Simultaneous events:
  - Both request in NONE: the prio requester wins; the loser keeps req high and is granted next cycle, unless the winner takes the lock.
  - Lock release and the other's request in the same cycle: the other requester is granted at the earliest on the following cycle.
- A requester must hold req/we/addr/wdata stable until it sees gnt.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs stat_gnt_a, stat_gnt_b and stat_stall, each 16 bits.
  - stat_gnt_a / stat_gnt_b: granted accesses per requester.
  - stat_stall: cycles in which a requester had req=1 and gnt=0.
  - All counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Shared package holds:
  - lock-state encoding constants: LK_NONE=2'd0, LK_A=2'd1, LK_B=2'd2;
  - requester index constants: REQ_A=0, REQ_B=1;
  - the stats counter width (16).
- One natural sub-module, arb_rr2: a 2-way round-robin grant with a lock mask.
  - Inputs: req[1:0], prio, lock_state.
  - Output: one-hot gnt[1:0].
- Datapath muxing and read-return tracking stay in the top module.

Test Plan:
- Reset, then a_req read of addr 0x0010 with RAM[0x0010]=0x5A -> a_gnt=1 the same cycle; a_rvalid=1 with a_rdata=0x5A the next cycle; b_rvalid stays 0.
- a_req and b_req reads asserted together for 4 cycles -> grants go A, B, A, B; each rvalid appears 1 cycle after its own grant.
- B writes 0x33 to 0x0200 with b_lock=1, then A and B both request -> A is stalled (a_gnt=0) until B makes a granted access with b_lock=0; A is granted in the cycle after that.
- A granted read with rst asserted in the same cycle -> no a_rvalid next cycle; prio=A; the next simultaneous request is granted to A.
- A writes 0xC3 to 0x3FFF, then reads it on the next cycle -> a_rvalid with 0xC3; mem_addr=0x3FFF on both cycles.
- ARB_STATS_EN defined, 3 contested cycles -> stat_stall=3; stat_gnt_a + stat_gnt_b = 3. Preloading a counter near 0xFFFF and continuing shows it holds at 0xFFFF.
